// File: rtl/ff_scan_pkg.sv
// Shared definitions for the flop-bank scan reader: FSM state encoding and
// the bit-counter width computation.
package ff_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/ff_scan_shreg.sv
// Loadable right-shift register feeding the serial output bit (LSB first).
// With FF_SCAN_READER_PARITY_EN the captured even parity is shifted in behind the data.
module ff_scan_shreg
    import ff_scan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             sdo_o
);

    logic [WIDTH-1:0] shreg_q;
    logic             fill_s;

`ifdef FF_SCAN_READER_PARITY_EN
    logic par_q;

    // Parity of the captured vector; it becomes bit 0 after WIDTH shifts.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load_i) begin
            par_q <= ^data_i;
        end
    end

    assign fill_s = par_q;
`else
    assign fill_s = 1'b0;
`endif

    // Capture or shift the data vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= {WIDTH{1'b0}};
        end else if (load_i) begin
            shreg_q <= data_i;
        end else if (shift_i) begin
            shreg_q <= {fill_s, shreg_q[WIDTH-1:1]};
        end
    end

    assign sdo_o = shreg_q[0];

endmodule

// File: rtl/ff_scan_reader.sv
// Captures a parallel flop vector and drains it serially over a valid/ready handshake.
// Optional trailing parity bit when FF_SCAN_READER_PARITY_EN is defined.
module ff_scan_reader
    import ff_scan_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_req,
    input  logic [WIDTH-1:0] par_in,
    output logic             sdo,
    output logic             sdo_valid,
    input  logic             sdo_ready,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sdo_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             load_s;
    logic             shift_s;

    assign load_s  = (state_q == ST_IDLE) && cap_req;
    assign shift_s = sdo_valid_q && sdo_ready;

    ff_scan_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load_s),
        .shift_i (shift_s),
        .data_i  (par_in),
        .sdo_o   (sdo)
    );

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            sdo_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (cap_req) begin
                        state_q     <= ST_SHIFT;
                        cnt_q       <= {CNT_W{1'b0}};
                        sdo_valid_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (shift_s) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_CNT) begin
`ifdef FF_SCAN_READER_PARITY_EN
                            state_q <= ST_PAR;
`else
                            state_q     <= ST_DONE;
                            sdo_valid_q <= 1'b0;
                            done_q      <= 1'b1;
`endif
                        end
                    end
                end
`ifdef FF_SCAN_READER_PARITY_EN
                ST_PAR: begin
                    if (shift_s) begin
                        state_q     <= ST_DONE;
                        sdo_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    sdo_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sdo_valid = sdo_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ff_scan_reader.sv
// Scoreboard bench for ff_scan_reader: stimulus pushes expected bit streams,
// a negedge monitor pops and compares on each accepted bit.
module tb_ff_scan_reader;

    localparam int WIDTH = 8;
`ifdef FF_SCAN_READER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cap_req = 1'b0;
    logic [WIDTH-1:0] par_in = 8'h00;
    logic             sdo;
    logic             sdo_valid;
    logic             sdo_ready = 1'b1;
    logic             busy;
    logic             done;

    int vectors = 0;
    int miscompares = 0;

    bit exp_q[$];
    int len_q[$];
    int burst_left = 0;
    int issued = 0;
    int completed = 0;
    bit mon_en = 1'b0;
    bit rand_ready = 1'b0;
    bit cap_expect = 1'b0;
    bit b2b = 1'b0;
    bit done_due = 1'b0;
    bit idle_due = 1'b0;
    bit start_due = 1'b0;
    bit stall_chk = 1'b0;
    bit stall_bit = 1'b0;

    ff_scan_reader #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cap_req   (cap_req),
        .par_in    (par_in),
        .sdo       (sdo),
        .sdo_valid (sdo_valid),
        .sdo_ready (sdo_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream: data LSB first, then even parity when enabled.
    task automatic push_expect(input logic [WIDTH-1:0] d);
        int ones = 0;
        for (int i = 0; i < WIDTH; i++) begin
            exp_q.push_back(((d >> i) & 1) == 1);
            ones += (d >> i) & 1;
        end
        if (NBITS > WIDTH) exp_q.push_back((ones % 2) == 1);
        len_q.push_back(NBITS);
    endtask

    task automatic capture(input logic [WIDTH-1:0] d);
        push_expect(d);
        issued++;
        par_in = d;
        cap_req = 1'b1;
        cap_expect = 1'b1;
        @(posedge clk); #1;
        cap_req = 1'b0;
        cap_expect = 1'b0;
        par_in = WIDTH'($urandom);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (completed < issued && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (completed < issued) begin
            miscompares++;
            $display("FAIL timeout: completed %0d expected %0d", completed, issued);
            completed = issued;
        end
    endtask

    task automatic flush_model();
        exp_q.delete();
        len_q.delete();
        burst_left = 0;
        done_due = 1'b0;
        idle_due = 1'b0;
        start_due = 1'b0;
        stall_chk = 1'b0;
        completed = issued;
    endtask

    // Consumer-side ready generation.
    always @(posedge clk) begin
        #1;
        sdo_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check("done", done, done_due);
            if (done_due) begin
                check("valid_in_done", sdo_valid, 1'b0);
                check("busy_in_done", busy, 1'b1);
                done_due = 1'b0;
                completed++;
                idle_due = 1'b1;
            end else if (idle_due) begin
                check("idle_busy", busy, 1'b0);
                check("idle_valid", sdo_valid, 1'b0);
                idle_due = 1'b0;
                if (b2b && len_q.size() > 0) start_due = 1'b1;
            end else if (start_due) begin
                check("first_valid", sdo_valid, 1'b1);
                check("first_busy", busy, 1'b1);
                start_due = 1'b0;
            end
            if (cap_expect) start_due = 1'b1;
            if (stall_chk) begin
                check("stall_valid", sdo_valid, 1'b1);
                check("stall_sdo", sdo, stall_bit);
            end
            stall_chk = sdo_valid && !sdo_ready;
            stall_bit = sdo;
            if (sdo_valid) check("busy_while_valid", busy, 1'b1);
            if (sdo_valid && sdo_ready) begin
                if (burst_left == 0) begin
                    if (len_q.size() == 0) begin
                        miscompares++;
                        vectors++;
                        $display("FAIL unexpected_bit: got sdo_valid 1 expected 0 at %0t", $time);
                    end else begin
                        burst_left = len_q.pop_front();
                    end
                end
                if (burst_left > 0) begin
                    check("sdo", sdo, exp_q.pop_front());
                    burst_left--;
                    if (burst_left == 0) done_due = 1'b1;
                end
            end else if (burst_left == 0 && len_q.size() == 0 && !done_due) begin
                check("quiet_valid", sdo_valid, 1'b0);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sdo", sdo, 1'b0);
        check("rst_valid", sdo_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Basic drain with ready held high.
        capture(8'hA5);
        wait_done();

        // Same vector under random backpressure.
        rand_ready = 1'b1;
        capture(8'hA5);
        wait_done();
        rand_ready = 1'b0;
        @(posedge clk); #1;

        // cap_req during a shift is ignored and not queued.
        capture(8'hA5);
        @(posedge clk); #1;
        par_in = 8'hFF;
        cap_req = 1'b1;
        @(posedge clk); #1;
        cap_req = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);
        #1;

        // Reset in the middle of a shift aborts it.
        capture(8'hA5);
        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush_model();
        @(negedge clk);
        check("abort_valid", sdo_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_sdo", sdo, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
            check("abort_quiet", sdo_valid, 1'b0);
        end
        @(posedge clk); #1;
        mon_en = 1'b1;
        capture(8'h3C);
        wait_done();

        // Parity-relevant vector (parity 1 when enabled).
        capture(8'h07);
        wait_done();

        // Back-to-back captures with cap_req held high.
        b2b = 1'b1;
        for (int i = 0; i < 3; i++) push_expect(8'hC3);
        issued += 3;
        par_in = 8'hC3;
        cap_req = 1'b1;
        cap_expect = 1'b1;
        @(posedge clk); #1;
        cap_expect = 1'b0;
        wait_done();
        cap_req = 1'b0;
        b2b = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Randomized vectors with random backpressure.
        rand_ready = 1'b1;
        for (int t = 0; t < 15; t++) begin
            capture(WIDTH'($urandom));
            wait_done();
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_bits: got %0d expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
